// File: rtl/ex2_sq_accum.sv
// Streaming sum-of-squares accumulator for the E[x^2] path of the layer-norm datapath.
// Optional build macro EX2_MEAN_SUM_EN adds a parallel sum-of-x output (out_sum).

module ex2_sq4_lut (
    input  logic [3:0] a_i,
    output logic [7:0] sq_o
);
    always_comb begin
        sq_o = '0;
        case (a_i)
            4'd0:  sq_o = 8'd0;
            4'd1:  sq_o = 8'd1;
            4'd2:  sq_o = 8'd4;
            4'd3:  sq_o = 8'd9;
            4'd4:  sq_o = 8'd16;
            4'd5:  sq_o = 8'd25;
            4'd6:  sq_o = 8'd36;
            4'd7:  sq_o = 8'd49;
            4'd8:  sq_o = 8'd64;
            4'd9:  sq_o = 8'd81;
            4'd10: sq_o = 8'd100;
            4'd11: sq_o = 8'd121;
            4'd12: sq_o = 8'd144;
            4'd13: sq_o = 8'd169;
            4'd14: sq_o = 8'd196;
            4'd15: sq_o = 8'd225;
            default: sq_o = '0;
        endcase
    end
endmodule

module ex2_sq_accum #(
    parameter int unsigned VEC_LEN = 64,
    parameter int unsigned ACC_W   = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum_sq
`ifdef EX2_MEAN_SUM_EN
    ,
    output logic [ACC_W-9:0] out_sum
`endif
);
    localparam int unsigned CNT_W = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned SUM_W = ACC_W - 8;

    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_last_q, s1_last_d;
    logic [7:0]       s1_hh_q, s1_hh_d;
    logic [7:0]       s1_ll_q, s1_ll_d;
    logic [7:0]       s1_hl_q, s1_hl_d;
    logic             s2_last_q, s2_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_sq_q, out_sum_sq_d;
`ifdef EX2_MEAN_SUM_EN
    logic [7:0]       s1_x_q, s1_x_d;
    logic [SUM_W-1:0] sum_acc_q, sum_acc_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
`endif

    logic [7:0] hh_c, ll_c, hl_c;
    logic       accept_c;
    logic       last_c;

    ex2_sq4_lut u_lut_h (.a_i(in_data[7:4]), .sq_o(hh_c));
    ex2_sq4_lut u_lut_l (.a_i(in_data[3:0]), .sq_o(ll_c));

    // Cross term h*l as a 4x4 shift-add
    always_comb begin
        hl_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_data[i]) hl_c = hl_c + (8'(in_data[7:4]) << i);
        end
    end

    assign in_ready = (state_q == ST_ACCUM) && !clear;
    assign accept_c = in_valid && in_ready;
    assign last_c   = (count_q == CNT_W'(VEC_LEN - 1));

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        s1_vld_d     = accept_c;
        s1_last_d    = s1_last_q;
        s1_hh_d      = s1_hh_q;
        s1_ll_d      = s1_ll_q;
        s1_hl_d      = s1_hl_q;
        s2_last_d    = s1_vld_q && s1_last_q;
        acc_d        = acc_q;
        out_valid_d  = out_valid_q;
        out_sum_sq_d = out_sum_sq_q;
`ifdef EX2_MEAN_SUM_EN
        s1_x_d       = s1_x_q;
        sum_acc_d    = sum_acc_q;
        out_sum_d    = out_sum_q;
`endif

        if (accept_c) begin
            s1_last_d = last_c;
            s1_hh_d   = hh_c;
            s1_ll_d   = ll_c;
            s1_hl_d   = hl_c;
`ifdef EX2_MEAN_SUM_EN
            s1_x_d    = in_data;
`endif
        end

        // x^2 = (h^2 << 8) + (h*l << 5) + l^2
        if (s1_vld_q) begin
            acc_d = acc_q + ACC_W'({s1_hh_q, 8'b0}) + ACC_W'({s1_hl_q, 5'b0})
                          + ACC_W'(s1_ll_q);
`ifdef EX2_MEAN_SUM_EN
            sum_acc_d = sum_acc_q + SUM_W'(s1_x_q);
`endif
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept_c) begin
                    if (last_c) begin
                        state_d = ST_DRAIN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (s2_last_q) begin
                    state_d      = ST_DONE;
                    out_valid_d  = 1'b1;
                    out_sum_sq_d = acc_q;
`ifdef EX2_MEAN_SUM_EN
                    out_sum_d    = sum_acc_q;
`endif
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_ACCUM;
                    out_valid_d = 1'b0;
                    acc_d       = '0;
`ifdef EX2_MEAN_SUM_EN
                    sum_acc_d   = '0;
`endif
                end
            end
            default: state_d = ST_ACCUM;
        endcase

        // Abort outranks everything, including a pending result
        if (clear) begin
            state_d     = ST_ACCUM;
            count_d     = '0;
            s1_vld_d    = 1'b0;
            s2_last_d   = 1'b0;
            acc_d       = '0;
            out_valid_d = 1'b0;
`ifdef EX2_MEAN_SUM_EN
            sum_acc_d   = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            count_q      <= '0;
            s1_vld_q     <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_hh_q      <= '0;
            s1_ll_q      <= '0;
            s1_hl_q      <= '0;
            s2_last_q    <= 1'b0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sum_sq_q <= '0;
`ifdef EX2_MEAN_SUM_EN
            s1_x_q       <= '0;
            sum_acc_q    <= '0;
            out_sum_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            s1_vld_q     <= s1_vld_d;
            s1_last_q    <= s1_last_d;
            s1_hh_q      <= s1_hh_d;
            s1_ll_q      <= s1_ll_d;
            s1_hl_q      <= s1_hl_d;
            s2_last_q    <= s2_last_d;
            acc_q        <= acc_d;
            out_valid_q  <= out_valid_d;
            out_sum_sq_q <= out_sum_sq_d;
`ifdef EX2_MEAN_SUM_EN
            s1_x_q       <= s1_x_d;
            sum_acc_q    <= sum_acc_d;
            out_sum_q    <= out_sum_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sum_sq = out_sum_sq_q;
`ifdef EX2_MEAN_SUM_EN
    assign out_sum    = out_sum_q;
`endif

endmodule

// File: tb/tb_ex2_sq_accum.sv
// Bench for ex2_sq_accum: four instances (VEC_LEN 4, 8, 16, 64) driven by directed steps
// and a randomized phase checked against a plain-arithmetic sum-of-squares model.
module tb_ex2_sq_accum;
    localparam int ACC_W = 22;

    logic             clk;
    logic             rst_n;
    logic             clear     [4];
    logic             in_valid  [4];
    logic             in_ready  [4];
    logic [7:0]       in_data   [4];
    logic             out_valid [4];
    logic             out_ready [4];
    logic [ACC_W-1:0] out_sum_sq[4];
    logic [ACC_W-9:0] out_sum   [4];

    int compared   = 0;
    int mismatched = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef EX2_MEAN_SUM_EN
    ex2_sq_accum #(.VEC_LEN(4), .ACC_W(ACC_W)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum_sq(out_sum_sq[0]), .out_sum(out_sum[0]));
    ex2_sq_accum #(.VEC_LEN(8), .ACC_W(ACC_W)) u_d8 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum_sq(out_sum_sq[1]), .out_sum(out_sum[1]));
    ex2_sq_accum #(.VEC_LEN(16), .ACC_W(ACC_W)) u_d16 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum_sq(out_sum_sq[2]), .out_sum(out_sum[2]));
    ex2_sq_accum #(.VEC_LEN(64), .ACC_W(ACC_W)) u_d64 (
        .clk(clk), .rst_n(rst_n), .clear(clear[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_sum_sq(out_sum_sq[3]), .out_sum(out_sum[3]));
`else
    ex2_sq_accum #(.VEC_LEN(4), .ACC_W(ACC_W)) u_d4 (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_sum_sq(out_sum_sq[0]));
    ex2_sq_accum #(.VEC_LEN(8), .ACC_W(ACC_W)) u_d8 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_sum_sq(out_sum_sq[1]));
    ex2_sq_accum #(.VEC_LEN(16), .ACC_W(ACC_W)) u_d16 (
        .clk(clk), .rst_n(rst_n), .clear(clear[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_sum_sq(out_sum_sq[2]));
    ex2_sq_accum #(.VEC_LEN(64), .ACC_W(ACC_W)) u_d64 (
        .clk(clk), .rst_n(rst_n), .clear(clear[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_sum_sq(out_sum_sq[3]));
    initial for (int i = 0; i < 4; i++) out_sum[i] = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input int d, input int exp);
`ifdef EX2_MEAN_SUM_EN
        chk(tag, 32'(out_sum[d]), exp);
`endif
    endtask

    // Present one sample on instance d and hold it until accepted
    task automatic push(input int d, input int x);
        logic rdy;
        bit   done;
        done = 1'b0;
        in_valid[d] = 1'b1;
        in_data[d]  = 8'(x);
        for (int n = 0; n < 200 && !done; n++) begin
            #1;
            rdy = in_ready[d];
            @(posedge clk);
            #1;
            done = rdy;
        end
        in_valid[d] = 1'b0;
        if (!done) chk("push_timeout", 32'(in_ready[d]), 1);
    endtask

    task automatic wait_out(input string tag, input int d, input int exp_sq, input int exp_s);
        for (int n = 0; n < 100 && !out_valid[d]; n++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, 32'(out_valid[d]), 1);
        chk({tag, "_sq"}, 32'(out_sum_sq[d]), exp_sq);
        chk_sum({tag, "_sum"}, d, exp_s);
    endtask

    initial begin
        int exp_q[$];
        int exps_q[$];
        int cur_sq, cur_s, cnt, got;
        bit acc, hs;
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            clear[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0; out_ready[d] = 1'b1;
        end
        #3;
        for (int d = 0; d < 4; d++) begin
            chk("rst_valid", 32'(out_valid[d]), 0);
            chk("rst_sq", 32'(out_sum_sq[d]), 0);
        end
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready[0]), 1);

        // Full-scale samples, output two edges after the last accept
        for (int i = 0; i < 4; i++) push(0, 255);
        chk("lat_t0", 32'(out_valid[0]), 0);
        @(posedge clk); #1;
        chk("lat_t1", 32'(out_valid[0]), 0);
        @(posedge clk); #1;
        chk("lat_t2", 32'(out_valid[0]), 1);
        chk("max_sq", 32'(out_sum_sq[0]), 260100);
        chk_sum("max_sum", 0, 1020);
        @(posedge clk); #1;
        chk("max_taken", 32'(out_valid[0]), 0);

        // Backpressure: result held, input stalled while out_ready low
        out_ready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) push(0, i);
        wait_out("bp", 0, 30, 10);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'd5;
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 32'(out_valid[0]), 1);
            chk("bp_hold_sq", 32'(out_sum_sq[0]), 30);
            chk("bp_hold_ready", 32'(in_ready[0]), 0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_taken", 32'(out_valid[0]), 0);
        for (int i = 0; i < 4; i++) push(0, 5);
        wait_out("bp_next", 0, 100, 20);

        // Clear with the 5th sample discards the vector and the sample
        for (int i = 0; i < 4; i++) push(1, 3);
        in_valid[1] = 1'b1;
        in_data[1]  = 8'd99;
        clear[1]    = 1'b1;
        #1;
        chk("clr_ready", 32'(in_ready[1]), 0);
        @(posedge clk); #1;
        clear[1] = 1'b0;
        in_valid[1] = 1'b0;
        chk("clr_valid", 32'(out_valid[1]), 0);
        out_ready[1] = 1'b0;
        for (int i = 0; i < 8; i++) push(1, 10);
        wait_out("clr_vec", 1, 800, 80);
        // Clear drops a pending result and empties the accumulator
        clear[1] = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        clear[1] = 1'b0;
        #1;
        chk("clr_drop_valid", 32'(out_valid[1]), 0);
        chk("clr_drop_ready", 32'(in_ready[1]), 1);
        for (int i = 0; i < 8; i++) push(1, 10);
        wait_out("clr_again", 1, 800, 80);

        // Nibble cross-term coverage
        for (int i = 0; i < 16; i++) push(2, i);
        wait_out("ramp_lo", 2, 1240, 120);
        for (int i = 0; i < 16; i++) push(2, 16 * i);
        wait_out("ramp_hi", 2, 317440, 1920);

        // Asynchronous reset mid-vector
        for (int i = 0; i < 3; i++) push(0, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid[0]), 0);
        chk("arst_sq0", 32'(out_sum_sq[0]), 0);
        chk("arst_sq1", 32'(out_sum_sq[1]), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready", 32'(in_ready[0]), 1);
        for (int i = 0; i < 4; i++) push(0, 7);
        wait_out("arst_vec", 0, 196, 28);

        // Randomized traffic on the VEC_LEN=64 instance against a sum model
        cur_sq = 0; cur_s = 0; cnt = 0; got = 0;
        in_valid[3] = 1'b0;
        for (int cyc = 0; cyc < 30000 && got < 6; cyc++) begin
            out_ready[3] = ($urandom_range(0, 3) != 0);
            if (!in_valid[3] && $urandom_range(0, 2) != 0) begin
                in_valid[3] = 1'b1;
                in_data[3]  = 8'($urandom_range(0, 255));
            end
            #1;
            acc = in_valid[3] && in_ready[3];
            hs  = out_valid[3] && out_ready[3];
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected", 32'(out_valid[3]), 0);
                end else begin
                    chk("rnd_sq", 32'(out_sum_sq[3]), exp_q.pop_front());
                    chk_sum("rnd_sum", 3, exps_q.pop_front());
                end
                got++;
            end
            if (acc) begin
                cur_sq += int'(in_data[3]) * int'(in_data[3]);
                cur_s  += int'(in_data[3]);
                cnt++;
                if (cnt == 64) begin
                    exp_q.push_back(cur_sq);
                    exps_q.push_back(cur_s);
                    cur_sq = 0; cur_s = 0; cnt = 0;
                end
            end
            @(posedge clk); #1;
            if (acc) in_valid[3] = 1'b0;
        end
        chk("rnd_results", 32'(got), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
